// File: rtl/q100_dtcm_if.sv
// q100_dtcm_if: DTCM port between the MEM stage and the data TCM.
// Master = MEM stage (requester), slave = q100_dtcm (responder).
interface q100_dtcm_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int BANK       = 4
);
    logic [ADDR_WIDTH-1:0] dtcm_rw_addr_i;
    logic [DATA_WIDTH-1:0] dtcm_wr_data_i;
    logic [BANK-1:0]       dtcm_rw_en_i;
    logic [DATA_WIDTH-1:0] dtcm_rd_data_o;
    logic                  dtcm_busy_o;
    logic                  dtcm_par_err_o;

    modport master (
        output dtcm_rw_addr_i,
        output dtcm_wr_data_i,
        output dtcm_rw_en_i,
        input  dtcm_rd_data_o,
        input  dtcm_busy_o,
        input  dtcm_par_err_o
    );

    modport slave (
        input  dtcm_rw_addr_i,
        input  dtcm_wr_data_i,
        input  dtcm_rw_en_i,
        output dtcm_rd_data_o,
        output dtcm_busy_o,
        output dtcm_par_err_o
    );
endinterface

// File: rtl/q100_dtcm.sv
// q100_dtcm: byte-lane data TCM, read-first, one-cycle read latency,
// clears itself after reset. Optional per-lane parity: Q100_DTCM_PARITY_EN.
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 14
`endif
`ifndef DTCM_DATA_WIDTH
`define DTCM_DATA_WIDTH 32
`endif
`ifndef DTCM_BANK
`define DTCM_BANK 4
`endif

module q100_dtcm #(
    parameter int ADDR_WIDTH = `DTCM_ADDR_WIDTH,
    parameter int DATA_WIDTH = `DTCM_DATA_WIDTH,
    parameter int BANK       = `DTCM_BANK
) (
    input logic        clk,
    input logic        rst,
    q100_dtcm_if.slave bus
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [IW-1:0]         clr_ptr;
    logic [IW-1:0]         word;
    logic                  ready;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  unused_lsb;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign word       = bus.dtcm_rw_addr_i[ADDR_WIDTH-1:2];
    assign unused_lsb = ^bus.dtcm_rw_addr_i[1:0];
    assign ready      = (state == ST_READY);

    assign bus.dtcm_rd_data_o = rd_q;
    assign bus.dtcm_busy_o    = busy_q;

    // Clear-engine FSM: walk every word once, then serve the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            busy_q  <= 1'b1;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == IW'(DEPTH - 1)) begin
                state  <= ST_READY;
                busy_q <= 1'b0;
            end
        end
    end

    // Array writes: zero fill while clearing, lane-masked stores when ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                mem[clr_ptr] <= '0;
            end else begin
                for (int k = 0; k < BANK; k++) begin
                    if (bus.dtcm_rw_en_i[k])
                        mem[word][8*k +: 8] <= bus.dtcm_wr_data_i[8*k +: 8];
                end
            end
        end
    end

    // Read-first data register, refreshed every ready cycle.
    always_ff @(posedge clk) begin
        if (rst)
            rd_q <= '0;
        else if (ready)
            rd_q <= mem[word];
    end

`ifdef Q100_DTCM_PARITY_EN
    logic [BANK-1:0] par_flip;
    logic [BANK-1:0] par_calc;
    logic            perr_q;
    logic [BANK-1:0] par_mem [DEPTH];

    assign par_flip           = '0;
    assign bus.dtcm_par_err_o = perr_q;

    // Recompute even parity of the addressed word's lanes.
    always_comb begin
        par_calc = '0;
        for (int k = 0; k < BANK; k++)
            par_calc[k] = ^mem[word][8*k +: 8];
    end

    // Parity store: zero while clearing, written alongside each lane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                par_mem[clr_ptr] <= '0;
            end else begin
                for (int k = 0; k < BANK; k++) begin
                    if (bus.dtcm_rw_en_i[k])
                        par_mem[word][k] <= ^bus.dtcm_wr_data_i[8*k +: 8]
                                            ^ par_flip[k];
                end
            end
        end
    end

    // Error flag aligned with rd_q.
    always_ff @(posedge clk) begin
        if (rst)
            perr_q <= 1'b0;
        else if (ready)
            perr_q <= |(par_calc ^ par_mem[word]);
    end
`else
    assign bus.dtcm_par_err_o = 1'b0;
`endif
endmodule
